// File: rtl/serial_addsub_nbit.sv
// Bit-serial N-bit adder/subtractor.
// It latches two operands and a mode bit on start. It then processes one bit
// pair per clock, LSB first, through a single full add/sub cell
// (a + (b ^ m) + cin). It collects the sum bits into a parallel result and
// reports the final carry and the two's-complement overflow.
module serial_addsub_nbit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             m,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] sh_a_reg;
    logic [WIDTH-1:0] sh_b_reg;
    logic [WIDTH-1:0] res_sh_reg;
    logic [WIDTH-1:0] result_reg;
    logic [CNT_W-1:0] count_reg;
    logic             m_reg;
    logic             carry_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic [WIDTH-1:0] sh_a_next;
    logic [WIDTH-1:0] sh_b_next;
    logic [WIDTH-1:0] res_sh_next;
    logic             b_eff;
    logic             sum_bit;
    logic             carry_next;
    logic             last_bit;

    // One full add/sub cell working on the current LSB pair.
    assign b_eff      = sh_b_reg[0] ^ m_reg;
    assign sum_bit    = sh_a_reg[0] ^ b_eff ^ carry_reg;
    assign carry_next = (sh_a_reg[0] & b_eff) | (sh_a_reg[0] & carry_reg) | (b_eff & carry_reg);
    assign last_bit   = (count_reg == CNT_W'(WIDTH - 1));

    // Operands shift right toward the cell. Sum bits enter the result shifter
    // at the MSB, so after WIDTH shifts the first bit has reached bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign sh_a_next[gi]   = sh_a_reg[gi + 1];
            assign sh_b_next[gi]   = sh_b_reg[gi + 1];
            assign res_sh_next[gi] = res_sh_reg[gi + 1];
        end
    endgenerate
    assign sh_a_next[WIDTH-1]   = 1'b0;
    assign sh_b_next[WIDTH-1]   = 1'b0;
    assign res_sh_next[WIDTH-1] = sum_bit;

    // Control FSM with datapath registers; every output comes from a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            sh_a_reg   <= '0;
            sh_b_reg   <= '0;
            res_sh_reg <= '0;
            result_reg <= '0;
            count_reg  <= '0;
            m_reg      <= 1'b0;
            carry_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                    if (start) begin
                        sh_a_reg   <= a;
                        sh_b_reg   <= b;
                        m_reg      <= m;
                        // Subtract is a + ~b + 1. The +1 enters as the initial carry.
                        carry_reg  <= m;
                        count_reg  <= '0;
                        res_sh_reg <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    sh_a_reg   <= sh_a_next;
                    sh_b_reg   <= sh_b_next;
                    res_sh_reg <= res_sh_next;
                    carry_reg  <= carry_next;
                    if (last_bit) begin
                        result_reg <= res_sh_next;
                        cout_reg   <= carry_next;
                        // Carry into the MSB differs from carry out of it.
                        ovf_reg    <= carry_reg ^ carry_next;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                        state_reg  <= DONE;
                    end else begin
                        count_reg <= count_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign result   = result_reg;
    assign cout     = cout_reg;
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_serial_addsub_nbit.sv
// Bench for serial_addsub_nbit. It drives an 8-bit instance with directed
// vectors, hand-written corner sequences and random operations. It drives a
// 4-bit instance with an exhaustive sweep. Expected values come from plain
// integer arithmetic.
module tb_serial_addsub_nbit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0, m8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] res8;

    logic       start4 = 1'b0, m4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] res4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_addsub_nbit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .m(m8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .cout(cout8), .overflow(ovf8)
    );

    serial_addsub_nbit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .m(m4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(res4), .cout(cout4), .overflow(ovf4)
    );

    typedef struct {
        string      nm;
        logic       m;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       c;
        logic       v;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] rd_res(input int w);
        return (w == 8) ? res8 : {4'b0, res4};
    endfunction
    function automatic logic rd_busy(input int w);
        return (w == 8) ? busy8 : busy4;
    endfunction
    function automatic logic rd_done(input int w);
        return (w == 8) ? done8 : done4;
    endfunction
    function automatic logic rd_cout(input int w);
        return (w == 8) ? cout8 : cout4;
    endfunction
    function automatic logic rd_ovf(input int w);
        return (w == 8) ? ovf8 : ovf4;
    endfunction

    // Reference: unsigned sum for result/carry, exact signed value for overflow.
    function automatic logic [9:0] model(input int w, input logic mm, input logic [7:0] aa, input logic [7:0] bb);
        int mask, ua, ub, s, sa, sb, ex, c;
        logic v;
        mask = (1 << w) - 1;
        ua   = int'(aa) & mask;
        ub   = int'(bb) & mask;
        s    = mm ? (ua + ((~ub) & mask) + 1) : (ua + ub);
        c    = (s >> w) & 1;
        sa   = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb   = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        ex   = mm ? (sa - sb) : (sa + sb);
        v    = (ex > (1 << (w - 1)) - 1) || (ex < -(1 << (w - 1)));
        return {v, c[0], 8'(s & mask)};
    endfunction

    // One complete operation with latency, pulse-width, hold and value checks.
    task automatic run_op(input int w, input logic mm, input logic [7:0] aa, input logic [7:0] bb,
                          input logic [7:0] er, input logic ec, input logic ev, input string nm);
        logic [7:0] prev;
        int         busy_n, cyc;
        bit         hold_ok;
        prev = rd_res(w);
        @(negedge clk);
        if (w == 8) begin m8 = mm; a8 = aa; b8 = bb; start8 = 1'b1; end
        else begin m4 = mm; a4 = aa[3:0]; b4 = bb[3:0]; start4 = 1'b1; end
        @(negedge clk);
        start8 = 1'b0; start4 = 1'b0;
        // Operands changing after acceptance must not matter.
        a8 = 8'($urandom); b8 = 8'($urandom); m8 = 1'($urandom);
        a4 = 4'($urandom); b4 = 4'($urandom); m4 = 1'($urandom);
        busy_n = 0; cyc = 0; hold_ok = 1'b1;
        while (!rd_done(w) && cyc < 40) begin
            if (rd_busy(w)) busy_n++;
            if (rd_res(w) !== prev) hold_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check({nm, ".done"}, 32'(rd_done(w)), 32'd1);
        check({nm, ".busy_len"}, 32'(busy_n), 32'(w));
        check({nm, ".busy_at_done"}, 32'(rd_busy(w)), 32'd0);
        check({nm, ".result"}, 32'(rd_res(w)), 32'(er));
        check({nm, ".cout"}, 32'(rd_cout(w)), 32'(ec));
        check({nm, ".ovf"}, 32'(rd_ovf(w)), 32'(ev));
        check({nm, ".hold"}, 32'(hold_ok), 32'd1);
        $display("op %s w=%0d m=%0d a=%0h b=%0h -> res=%0h c=%0d v=%0d", nm, w, mm, aa, bb,
                 rd_res(w), rd_cout(w), rd_ovf(w));
        @(negedge clk);
        check({nm, ".done_pulse"}, 32'(rd_done(w)), 32'd0);
    endtask

    initial begin
        vec_t       tbl[10];
        logic [9:0] exp;
        logic [7:0] ra, rb;
        logic       rm;
        int         done_n, first_acc, cyc;

        tbl[0] = '{"add_basic", 1'b0, 8'h3C, 8'h0A, 8'h46, 1'b0, 1'b0};
        tbl[1] = '{"add_wrap",  1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{"add_ovf",   1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{"sub_pos",   1'b1, 8'h50, 8'h20, 8'h30, 1'b1, 1'b0};
        tbl[4] = '{"sub_borrow",1'b1, 8'h20, 8'h50, 8'hD0, 1'b0, 1'b0};
        tbl[5] = '{"sub_ovf",   1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        tbl[6] = '{"sub_zero",  1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[7] = '{"add_negov", 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        tbl[8] = '{"sub_posov", 1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};
        tbl[9] = '{"add_ones",  1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst.busy", 32'(busy8), 32'd0);
        check("rst.done", 32'(done8), 32'd0);
        check("rst.result", 32'(res8), 32'd0);
        check("rst.cout", 32'(cout8), 32'd0);
        check("rst.ovf", 32'(ovf8), 32'd0);
        check("rst4.result", 32'(res4), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors.
        for (int i = 0; i < 10; i++)
            run_op(8, tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].nm);

        // Starts during RUN and DONE are ignored; next accept is 10 edges after E0.
        @(negedge clk);
        m8 = 1'b0; a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        done_n = 0; first_acc = -1;
        for (int k = 0; k <= 10; k++) begin
            if (k == 2) begin start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; end
            if (k == 3) start8 = 1'b0;
            if (done8) begin
                done_n++;
                check("ign.result", 32'(res8), 32'h02);
                start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
            end
            if (k > 8 && busy8 && first_acc < 0) begin
                first_acc = k;
                start8 = 1'b0;
            end
            @(negedge clk);
        end
        check("ign.done_count", 32'(done_n), 32'd1);
        check("ign.next_accept", 32'(first_acc), 32'd10);
        start8 = 1'b0;
        cyc = 0;
        while (!done8 && cyc < 30) begin @(negedge clk); cyc++; end
        check("ign.second_result", 32'(res8), 32'hFF);
        $display("op ignored_start seq -> res=%0h accept_gap=%0d", res8, first_acc);
        @(negedge clk);

        // Reset in the middle of an operation discards it.
        m8 = 1'b0; a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst.busy", 32'(busy8), 32'd0);
        check("midrst.done", 32'(done8), 32'd0);
        check("midrst.result", 32'(res8), 32'd0);
        check("midrst.cout", 32'(cout8), 32'd0);
        check("midrst.ovf", 32'(ovf8), 32'd0);
        $display("op midrun_reset -> res=%0h busy=%0d", res8, busy8);
        run_op(8, 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, "after_rst");

        // Reset together with start: no operation starts.
        rst_n = 1'b0; start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
        @(negedge clk);
        rst_n = 1'b1; start8 = 1'b0;
        check("rst_start.busy", 32'(busy8), 32'd0);
        @(negedge clk);
        check("rst_start.busy2", 32'(busy8), 32'd0);
        check("rst_start.result", 32'(res8), 32'd0);
        $display("op reset_with_start -> busy=%0d", busy8);

        // Random 8-bit operations.
        for (int i = 0; i < 150; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rm = 1'($urandom);
            exp = model(8, rm, ra, rb);
            run_op(8, rm, ra, rb, exp[7:0], exp[8], exp[9], "rnd8");
        end

        // Exhaustive 4-bit sweep.
        for (int mi = 0; mi < 2; mi++)
            for (int ai = 0; ai < 16; ai++)
                for (int bi = 0; bi < 16; bi++) begin
                    exp = model(4, 1'(mi), 8'(ai), 8'(bi));
                    run_op(4, 1'(mi), 8'(ai), 8'(bi), exp[7:0], exp[8], exp[9], "sweep4");
                end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_addsub_nbit.md
Name: serial_addsub_nbit

Overview:
- Bit-serial N-bit adder/subtractor built around the team's 1-bit full add/sub cell (`a + (b XOR m) + cin`).
- Sits directly upstream of that cell and drives it. It latches two N-bit operands and a mode bit, then presents one bit pair per clock, LSB first. A carry flip-flop holds the carry between bits.
- It collects the sum bits into a parallel result and reports carry-out and signed overflow.
- It trades throughput for area where a ripple N-bit adder is too large.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width. Derived from WIDTH; not overridden.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- start  input  1  request pulse. Accepted only in IDLE.
- m  input  1  mode: 0 = add (a+b), 1 = subtract (a−b). Sampled with start.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: result, cout and overflow are valid.
- result  output  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  output  1  final carry. For add: unsigned carry. For sub: 1 = no borrow (a ≥ b unsigned).
- overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State returns to IDLE; bit counter cleared.
  - busy=0, done=0, result=0, cout=0, overflow=0.
  - Internal shift registers and carry flip-flop are cleared.
  - Reset overrides everything, including mid-RUN. A partial result is discarded; it does not appear on result.
- Three states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0. result, cout and overflow hold their last values.
  - On an edge with start=1: latch a into sh_a and b into sh_b; latch m; set carry FF = m (the subtract "+1"); clear count and the result shift register; go to RUN.
- RUN (busy=1): on each edge,
  - bit = sh_a[0] ^ (sh_b[0] ^ m_q) ^ carry;
  - carry_next = majority(sh_a[0], sh_b[0]^m_q, carry);
  - shift sh_a and sh_b right by 1;
  - shift bit into the MSB of the result shift register (result builds LSB-first from the top);
  - count++.
  - On the edge where count reaches WIDTH−1 (the WIDTH-th processed bit):
    - the shifted result register loads onto result;
    - cout = carry_next;
    - overflow = carry-in to that bit XOR carry_next;
    - go to DONE.
- DONE:
  - done=1, busy=0 for exactly one cycle, then IDLE on the next edge unconditionally.
  - start during DONE is ignored; no back-to-back accept.
- Latency:
  - start sampled at edge E0; bits processed at edges E1..E_WIDTH.
  - done high in the cycle after E_WIDTH; result valid from that cycle.
  - Initiation interval WIDTH+2 cycles.
- Input-change rules:
  - start and all inputs are ignored while busy=1 or done=1.
  - Changes to a, b or m after the accepting edge do not affect the operation in flight.
- Output hold: result, cout and overflow change only on the completion edge or on reset. They are stable throughout the next operation until its completion.
- Width rule: result is exact modulo 2^WIDTH; no saturation.
- Simultaneous events: rst_n=0 together with start=1 → reset wins; no operation starts.

Test Plan:
- WIDTH=8, add m=0, a=0x3C, b=0x0A, start at E0 → busy high for 8 cycles; done pulse in the cycle after E8; result=0x46, cout=0, overflow=0.
- Add carry/wrap: a=0xFF, b=0x01, m=0 → result=0x00, cout=1, overflow=0. Then a=0x7F, b=0x01 → result=0x80, cout=0, overflow=1.
- Subtract m=1: a=0x50, b=0x20 → result=0x30, cout=1, overflow=0. Then a=0x20, b=0x50 → result=0xD0, cout=0, overflow=0. Then a=0x80, b=0x01 → result=0x7F, cout=1, overflow=1.
- Ignored start: start a=0x01, b=0x01, then pulse start with a=0xAA, b=0x55 at cycles 3 and DONE → single done pulse, result=0x02, exactly 10 cycles between the accepting edge and the next possible accept.
- Reset mid-op: start 0x12+0x34, drive rst_n=0 for one edge at RUN cycle 4 → next cycle busy=0, done=0, result=0x00, cout=0. A subsequent 0x12+0x34 completes with result=0x46.
- Exhaustive sweep at WIDTH=4: every a, b, m (512 ops) compared against a reference model for result, cout, overflow; done pulses exactly once per op and busy width is always 4 cycles.
